dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the CPU datapath. It serves the load/store requests the datapath issues: a 64-bit byte address, a read or write strobe, 64-bit store data and a transfer size. Unlike a single-cycle memory, it accepts one request at a time through a valid/ready handshake, waits a programmable latency, then returns one response pulse. It lets the pipelined datapath be exercised against realistic multi-cycle memory, with big-endian byte ordering and alignment checking.

## Interface
Parameters:
- DEPTH_BYTES, 1024 — memory size in bytes; a power of two, multiple of 8
- LATENCY, 2 — wait cycles between accept and response (0..15)

Ports:
- clk  in  1  — single clock; all state changes on its rising edge
- reset_n  in  1  — reset is asynchronous and active-low
- req_valid  in  1  — request present
- req_ready  out  1  — responder can accept a request
- address  in  64  — byte address
- mem_write  in  1  — request is a store
- mem_read  in  1  — request is a load
- wr_data  in  64  — store data; the low 8·n bits are used
- xfer_size  in  4  — transfer bytes n ∈ {1,2,4,8}
- rsp_valid  out  1  — one-cycle response pulse
- rd_data  out  64  — load result, zero-extended
- err  out  1  — request rejected; meaningful only while rsp_valid=1

## Operation
- State machine has three states:
  - IDLE: req_ready=1.
  - WAIT: counts LATENCY cycles.
  - RESP: rsp_valid=1 for exactly one cycle.
- Accept: req_valid & req_ready at a rising edge.
  - Latches address, mem_write, mem_read, wr_data and xfer_size.
  - Goes to WAIT, or directly to RESP when LATENCY=0.
- Inputs are ignored outside IDLE.
- Error conditions (any one sets err=1):
  - mem_write == mem_read (both set or neither set)
  - xfer_size not in {1,2,4,8}
  - address not a multiple of xfer_size
  - address ≥ DEPTH_BYTES
- An errored request writes nothing and returns rd_data=0.
- Byte order is big-endian.
- Load of n bytes at address a:
  - rd_data[8n-1:0] = {mem[a], mem[a+1], …, mem[a+n-1]}
  - Upper bits are 0.
- Store of n bytes at address a:
  - mem[a+i] = wr_data[8(n-i)-1 : 8(n-i)-8] for i = 0..n-1.
  - No other byte changes.
  - rd_data=0 in the response.
- The write commits at the edge that enters RESP. A request accepted later therefore always sees it.
- Memory array contents are not affected by reset; initial contents are undefined.

## Timing
- Accept edge is cycle 0.
- WAIT occupies cycles 1..LATENCY.
- RESP is at cycle LATENCY+1; rsp_valid, rd_data and err are valid there.
- Back in IDLE at cycle LATENCY+2 with req_ready=1.
- Throughput: one request per LATENCY+2 cycles.
- req_ready is 0 in WAIT and RESP. There is no combinational path from req_valid to req_ready.
- rd_data and err are registered. They hold their last response value until the next RESP.
- Reset values: req_ready=1, rsp_valid=0, rd_data=0, err=0, state IDLE, wait counter 0.
- Reset asserted mid-request:
  - The request is dropped immediately.
  - If asserted before the RESP-entry edge, no store is committed.
  - No response is ever produced for it.
- The wait counter loads LATENCY on accept and decrements to 0. It never wraps.

## Test plan
- Store 8 bytes 0x0011223344556677 at address 0x10, then load 8 at 0x10 -> rd_data=0x0011223344556677, err=0, rsp_valid at cycle LATENCY+1 after each accept.
- After the prior store, load 1 at 0x13 and load 2 at 0x14 -> 0x33 and 0x4455 respectively. Then store 1 byte 0xAB at 0x11 and reload 8 at 0x10 -> 0x00AB223344556677.
- Load 4 at 0x12 (misaligned); load 8 at DEPTH_BYTES; request with mem_read=mem_write=1; xfer_size=3 -> each gives err=1, rd_data=0, and the memory is unchanged on reload.
- Hold req_valid high continuously with LATENCY=2 -> accepts spaced exactly 4 cycles apart; req_ready=0 in the 3 cycles after each accept; exactly one rsp_valid pulse per request.
- LATENCY=0 build: a store followed by a back-to-back load of the same address -> the load returns the new data, with responses 2 cycles apart.
- Assert reset_n=0 in cycle 1 of a store (LATENCY=2) -> outputs return to reset values asynchronously, no rsp_valid, and a later load of that address returns the old data.

Source files
------------

// File: rtl/dmem_responder.sv
// Multi-cycle big-endian data memory with a valid/ready request handshake.
// Each request gets exactly one response pulse, LATENCY+1 cycles after acceptance.
module dmem_responder #(
  parameter int unsigned DEPTH_BYTES = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] address,
  input  logic        mem_write,
  input  logic        mem_read,
  input  logic [63:0] wr_data,
  input  logic [3:0]  xfer_size,
  output logic        rsp_valid,
  output logic [63:0] rd_data,
  output logic        err
);

  localparam int unsigned AW = $clog2(DEPTH_BYTES);
  localparam bit ZeroLat = (LATENCY == 0);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] addr_q, wdata_q;
  logic        wr_q, rd_q;
  logic [3:0]  size_q;
  logic [63:0] rd_data_q;
  logic        err_q;
  logic        accept, commit;

  logic [63:0] s_addr, s_wdata;
  logic        s_wr, s_rd;
  logic [3:0]  s_size;
  logic        size_ok, aligned, in_range, req_err;
  logic [AW-1:0] idx [8];
  logic [5:0]    lane [8];
  logic [7:0]    active;
  logic [63:0]   load_val;

  logic [7:0] mem [DEPTH_BYTES];

  assign accept    = req_valid && (state_q == StIdle);
  assign req_ready = (state_q == StIdle);
  assign rsp_valid = (state_q == StResp);
  assign rd_data   = rd_data_q;
  assign err       = err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (ZeroLat) begin
            state_d = StResp;
            commit  = 1'b1;
            cnt_d   = 4'd0;
          end else begin
            state_d = StWait;
            cnt_d   = 4'(LATENCY);
          end
        end
      end
      StWait: begin
        if (cnt_q <= 4'd1) begin
          state_d = StResp;
          commit  = 1'b1;
        end
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Zero-latency requests commit on the accept edge, so they bypass the latches.
  always_comb begin
    if (state_q == StIdle) begin
      s_addr  = address;
      s_wdata = wr_data;
      s_wr    = mem_write;
      s_rd    = mem_read;
      s_size  = xfer_size;
    end else begin
      s_addr  = addr_q;
      s_wdata = wdata_q;
      s_wr    = wr_q;
      s_rd    = rd_q;
      s_size  = size_q;
    end
  end

  always_comb begin
    size_ok  = (s_size == 4'd1) || (s_size == 4'd2) || (s_size == 4'd4) || (s_size == 4'd8);
    aligned  = ((s_addr[3:0] & (s_size - 4'd1)) == 4'd0);
    in_range = (s_addr[63:AW] == '0);
    req_err  = (s_wr == s_rd) || !size_ok || !aligned || !in_range;
  end

  // Byte i of the transfer lives at address a+i and in data lane n-1-i (big-endian).
  always_comb begin
    load_val = '0;
    active   = '0;
    for (int i = 0; i < 8; i++) begin
      idx[i]    = s_addr[AW-1:0] + AW'(i);
      lane[i]   = {3'(s_size - 4'd1 - 4'(i)), 3'b000};
      active[i] = size_ok && (4'(i) < s_size);
      if (active[i]) load_val[lane[i] +: 8] = mem[idx[i]];
    end
  end

  always_ff @(posedge clk) begin
    if (commit && reset_n && s_wr && !req_err) begin
      for (int i = 0; i < 8; i++) begin
        if (active[i]) mem[idx[i]] <= s_wdata[lane[i] +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      size_q    <= 4'd0;
      rd_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= address;
        wdata_q <= wr_data;
        wr_q    <= mem_write;
        rd_q    <= mem_read;
        size_q  <= xfer_size;
      end
      if (commit) begin
        rd_data_q <= (s_rd && !req_err) ? load_val : 64'd0;
        err_q     <= req_err;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: a LATENCY=2 responder for the main sequence and a LATENCY=0
// instance for the back-to-back store/load case.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        req_valid, req_ready, mem_write, mem_read, rsp_valid, err;
  logic [63:0] address, wr_data, rd_data;
  logic [3:0]  xfer_size;

  logic        z_req_valid, z_req_ready, z_mem_write, z_mem_read, z_rsp_valid, z_err;
  logic [63:0] z_address, z_wr_data, z_rd_data;
  logic [3:0]  z_xfer_size;

  int n_checks = 0;
  int n_errors = 0;

  dmem_responder #(.DEPTH_BYTES(1024), .LATENCY(2)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .address(address), .mem_write(mem_write), .mem_read(mem_read), .wr_data(wr_data),
    .xfer_size(xfer_size), .rsp_valid(rsp_valid), .rd_data(rd_data), .err(err)
  );

  dmem_responder #(.DEPTH_BYTES(1024), .LATENCY(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .req_valid(z_req_valid), .req_ready(z_req_ready),
    .address(z_address), .mem_write(z_mem_write), .mem_read(z_mem_read),
    .wr_data(z_wr_data), .xfer_size(z_xfer_size), .rsp_valid(z_rsp_valid),
    .rd_data(z_rd_data), .err(z_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One request on the LATENCY=2 instance; returns at the negedge of the RESP cycle.
  task automatic xfer(input string tag, input logic wr, input logic rd, input logic [63:0] a,
                      input logic [63:0] d, input logic [3:0] n, output logic [63:0] q,
                      output logic e);
    int cyc;
    @(negedge clk);
    mem_write = wr;
    mem_read  = rd;
    address   = a;
    wr_data   = d;
    xfer_size = n;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1;
    while (!rsp_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_lat"}, 64'(cyc), 64'd3);
    q = rd_data;
    e = err;
  endtask

  logic [63:0] q;
  logic        e;
  logic [11:0] rdy_seen, rsp_seen, rdy_exp, rsp_exp;
  logic        rsp_any;

  initial begin
    reset_n   = 1'b0;
    req_valid = 1'b0; mem_write = 1'b0; mem_read = 1'b0;
    address   = '0;   wr_data   = '0;   xfer_size = 4'd0;
    z_req_valid = 1'b0; z_mem_write = 1'b0; z_mem_read = 1'b0;
    z_address   = '0;   z_wr_data   = '0;   z_xfer_size = 4'd0;
    repeat (2) @(negedge clk);
    check("rst_ready", 64'(req_ready), 64'd1);
    check("rst_rsp",   64'(rsp_valid), 64'd0);
    check("rst_rd",    rd_data, 64'd0);
    check("rst_err",   64'(err), 64'd0);
    reset_n = 1'b1;

    xfer("st8", 1, 0, 64'h10, 64'h0011223344556677, 4'd8, q, e);
    check("st8_rd", q, 64'd0);
    check("st8_err", 64'(e), 64'd0);
    @(negedge clk);
    check("pulse_once", 64'(rsp_valid), 64'd0);
    xfer("ld8", 0, 1, 64'h10, 64'h0, 4'd8, q, e);
    check("ld8_rd", q, 64'h0011223344556677);
    check("ld8_err", 64'(e), 64'd0);
    repeat (3) @(negedge clk);
    check("rd_hold", rd_data, 64'h0011223344556677);
    xfer("ld1", 0, 1, 64'h13, 64'h0, 4'd1, q, e);
    check("ld1_rd", q, 64'h33);
    xfer("ld2", 0, 1, 64'h14, 64'h0, 4'd2, q, e);
    check("ld2_rd", q, 64'h4455);
    xfer("st1", 1, 0, 64'h11, 64'hFFFF_FFFF_FFFF_FFAB, 4'd1, q, e);
    check("st1_err", 64'(e), 64'd0);
    xfer("reld", 0, 1, 64'h10, 64'h0, 4'd8, q, e);
    check("reld_rd", q, 64'h00AB223344556677);

    // Error cases; the first follows a nonzero load so rd_data=0 is a real change.
    xfer("mis", 0, 1, 64'h12, 64'h0, 4'd4, q, e);
    check("mis_err", 64'(e), 64'd1);
    check("mis_rd", q, 64'd0);
    xfer("oob", 0, 1, 64'd1024, 64'h0, 4'd8, q, e);
    check("oob_err", 64'(e), 64'd1);
    xfer("both", 1, 1, 64'h10, 64'hDEAD_BEEF_DEAD_BEEF, 4'd8, q, e);
    check("both_err", 64'(e), 64'd1);
    check("both_rd", q, 64'd0);
    xfer("sz3", 1, 0, 64'h10, 64'hCAFE_CAFE_CAFE_CAFE, 4'd3, q, e);
    check("sz3_err", 64'(e), 64'd1);
    xfer("none", 0, 0, 64'h10, 64'h0, 4'd8, q, e);
    check("none_err", 64'(e), 64'd1);
    xfer("mstw", 1, 0, 64'h14, 64'h1234_5678, 4'd8, q, e);
    check("mstw_err", 64'(e), 64'd1);
    xfer("unch", 0, 1, 64'h10, 64'h0, 4'd8, q, e);
    check("unch_rd", q, 64'h00AB223344556677);
    check("unch_err", 64'(e), 64'd0);

    // Continuous req_valid: accepts every 4 cycles.
    @(negedge clk);
    mem_write = 1'b0; mem_read = 1'b1; address = 64'h10; xfer_size = 4'd8;
    req_valid = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      rdy_seen[k] = req_ready;
      rsp_seen[k] = rsp_valid;
      rdy_exp[k]  = (k % 4 == 3);
      rsp_exp[k]  = (k % 4 == 2);
    end
    req_valid = 1'b0;
    check("bb_ready", 64'(rdy_seen), 64'(rdy_exp));
    check("bb_rsp",   64'(rsp_seen), 64'(rsp_exp));
    check("bb_rd", rd_data, 64'h00AB223344556677);

    // Reset in cycle 1 of a store must drop it.
    xfer("old", 1, 0, 64'h18, 64'h8877665544332211, 4'd8, q, e);
    xfer("oldl", 0, 1, 64'h18, 64'h0, 4'd8, q, e);
    check("oldl_rd", q, 64'h8877665544332211);
    @(negedge clk);
    mem_write = 1'b1; mem_read = 1'b0; address = 64'h18;
    wr_data = 64'h0BAD_0BAD_0BAD_0BAD; xfer_size = 4'd8; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check("mid_busy", 64'(req_ready), 64'd0);
    #1 reset_n = 1'b0;
    #1;
    check("mid_ready", 64'(req_ready), 64'd1);
    check("mid_rd", rd_data, 64'd0);
    check("mid_rsp", 64'(rsp_valid), 64'd0);
    rsp_any = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      rsp_any |= rsp_valid;
    end
    reset_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      rsp_any |= rsp_valid;
    end
    check("mid_norsp", 64'(rsp_any), 64'd0);
    xfer("after", 0, 1, 64'h18, 64'h0, 4'd8, q, e);
    check("after_rd", q, 64'h8877665544332211);

    // LATENCY=0: store then back-to-back load of the same address.
    @(negedge clk);
    z_mem_write = 1'b1; z_mem_read = 1'b0; z_address = 64'h20;
    z_wr_data = 64'h0102030405060708; z_xfer_size = 4'd8; z_req_valid = 1'b1;
    @(negedge clk);
    check("z_st_rsp", 64'(z_rsp_valid), 64'd1);
    check("z_st_err", 64'(z_err), 64'd0);
    z_mem_write = 1'b0; z_mem_read = 1'b1;
    @(negedge clk);
    check("z_gap", {62'd0, z_req_ready, z_rsp_valid}, 64'd2);
    @(negedge clk);
    z_req_valid = 1'b0;
    check("z_ld_rsp", 64'(z_rsp_valid), 64'd1);
    check("z_ld_rd", z_rd_data, 64'h0102030405060708);
    check("z_ld_err", 64'(z_err), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
